// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory for the single-cycle CPU datapath.
//
// Supports byte, halfword and word loads/stores (little-endian) with sign or
// zero extension on narrow loads, flags misaligned and out-of-range accesses,
// keeps a sticky fault bit, and zeroes every word with a hardware clear
// sequencer after each reset.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   addr     in  32   byte address of the access
//   wdata    in  32   store data (low byte/halfword used for narrow stores)
//   we       in   1   store request
//   re       in   1   load request (only used for fault detection)
//   size     in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   uns      in   1   1 = zero-extend narrow loads, 0 = sign-extend
//   rdata    out 32   combinational load result
//   misalign out  1   current access is misaligned or size is illegal
//   oor      out  1   current access is out of range
//   fault    out  1   sticky: a faulting access occurred since reset
//   busy     out  1   clear sequencer is running
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        oor,
    output logic        fault,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [31:0]      MEM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  clr_idx_q;
    logic [IDX_W-1:0]  clr_idx_d;
    logic              fault_q;
    logic              fault_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  widx;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              bad;
    logic              store_ok;
    logic              access_fault;
    logic [3:0]        be;
    logic [31:0]       wd;

    assign widx    = addr[IDX_W+1:2];
    assign rd_word = mem[widx];

    assign misalign = ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00))
                    | (size == 2'b11);
    assign oor      = (addr >= MEM_BYTES);
    assign bad      = misalign | oor;
    assign busy     = (state_q == CLEAR);
    assign fault    = fault_q;

    assign store_ok     = we & ~bad & ~busy;
    assign access_fault = (we | re) & bad & ~busy;
    assign fault_d      = fault_q | access_fault;
    assign clr_idx_d    = clr_idx_q + 1'b1;

    // Load path: pick the lane(s), then extend. Bad or busy accesses read 0.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        rdata   = '0;
        rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        if (!bad && !busy) begin
            case (size)
                2'b00:   rdata = uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                2'b01:   rdata = uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                2'b10:   rdata = rd_word;
                default: rdata = '0;
            endcase
        end
    end

    // Store lanes: replicate narrow data across the word and enable only
    // the addressed lanes.
    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (size)
            2'b00: begin
                be = 4'b0001 << addr[1:0];
                wd = {4{wdata[7:0]}};
            end
            2'b01: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Clear sequencer and sticky fault.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            fault_q <= fault_d;
            if (state_q == CLEAR) begin
                clr_idx_q <= clr_idx_d;
                if (clr_idx_q == LAST_IDX) begin
                    state_q <= READY;
                end
            end
        end
    end

    // NOTE: the storage array has no reset branch; it is zeroed word by word
    // by the clear sequencer, which keeps it mappable onto a RAM macro.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                mem[clr_idx_q] <= '0;
            end else if (store_ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[widx][8*b +: 8] <= wd[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl. A byte-array
// reference model with a clear countdown predicts every output; directed
// scenarios are followed by randomized traffic with occasional resets.
module tb_data_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        uns = 1'b0;
    logic [31:0] rdata;
    logic        misalign;
    logic        oor;
    logic        fault;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    byte unsigned m_mem [NBYTES];
    int           m_clr_left = DEPTH;
    bit           m_fault = 1'b0;

    logic [31:0] last_rdata;
    logic        last_mis, last_oor, last_busy, last_fault;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .size     (size),
        .uns      (uns),
        .rdata    (rdata),
        .misalign (misalign),
        .oor      (oor),
        .fault    (fault),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_misalign(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic bit m_oor(input logic [31:0] a);
        return a >= 32'(NBYTES);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic [1:0] sz, input bit u);
        int n;
        longint v;
        if (m_clr_left > 0 || m_misalign(a, sz) || m_oor(a)) return 32'd0;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(m_mem[int'(a) + i]) << (8 * i);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic m_step(input bit r, input bit w, input bit rd, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd);
        bit b;
        if (!r) begin
            m_clr_left = DEPTH;
            m_fault = 1'b0;
        end else if (m_clr_left > 0) begin
            for (int i = 0; i < 4; i++) m_mem[4 * (DEPTH - m_clr_left) + i] = 8'h00;
            m_clr_left--;
        end else begin
            b = m_misalign(a, sz) || m_oor(a);
            if ((w || rd) && b) m_fault = 1'b1;
            if (w && !b) begin
                for (int i = 0; i < (1 << sz); i++) m_mem[int'(a) + i] = wd[8*i +: 8];
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, compare just after, then
    // advance the model on the rising edge.
    task automatic cycle(input bit r, input bit w, input bit rd, input logic [31:0] a,
                         input logic [1:0] sz, input bit u, input logic [31:0] wd, input bit chk);
        @(negedge clk);
        rst_n = r; we = w; re = rd; addr = a; size = sz; uns = u; wdata = wd;
        #1;
        if (chk) begin
            check("busy", {31'b0, busy}, {31'b0, m_clr_left > 0});
            check("fault", {31'b0, fault}, {31'b0, m_fault});
            check("misalign", {31'b0, misalign}, {31'b0, m_misalign(a, sz)});
            check("oor", {31'b0, oor}, {31'b0, m_oor(a)});
            check("rdata", rdata, m_rdata(a, sz, u));
        end
        last_rdata = rdata; last_mis = misalign; last_oor = oor;
        last_busy = busy; last_fault = fault;
        @(posedge clk);
        m_step(r, w, rd, a, sz, wd);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic rst_cycle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        cycle(1'b1, 1'b1, 1'b0, a, sz, 1'b0, wd, 1'b1);
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] exp);
        cycle(1'b1, 1'b0, 1'b1, a, sz, u, 32'h0, 1'b1);
        check(tag, last_rdata, exp);
    endtask

    // Counts idle cycles observed with busy=1 until it drops (bounded).
    task automatic wait_clear(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            idle();
            if (last_busy) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [1:0]  sz;
        int sel;

        // Clear timing after a two-edge reset.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
        rst_cycle();
        wait_clear(n);
        check("clear_len", n, 64);
        for (int i = 0; i < NBYTES; i += 4) ld("clear_zero", 32'(i), 2'b10, 1'b0, 32'h0);

        // Word store then narrow loads.
        st(32'h10, 2'b10, 32'h8000_F0A5);
        ld("lb_s", 32'h10, 2'b00, 1'b0, 32'hFFFF_FFA5);
        ld("lb_u", 32'h10, 2'b00, 1'b1, 32'h0000_00A5);
        ld("lh_s", 32'h12, 2'b01, 1'b0, 32'hFFFF_8000);
        ld("lh_u", 32'h12, 2'b01, 1'b1, 32'h0000_8000);
        ld("lw", 32'h10, 2'b10, 1'b0, 32'h8000_F0A5);

        // Byte and halfword merge.
        st(32'h21, 2'b00, 32'h0000_007F);
        st(32'h22, 2'b01, 32'h0000_BEEF);
        ld("merge", 32'h20, 2'b10, 1'b0, 32'hBEEF_7F00);

        // Simultaneous store and load: old data visible, new after the edge.
        cycle(1'b1, 1'b1, 1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b1);
        check("rw_old", last_rdata, 32'hBEEF_7F00);
        ld("rw_new", 32'h20, 2'b10, 1'b0, 32'hCAFE_F00D);

        // Misalign and range.
        st(32'h06, 2'b10, 32'h1234_5678);
        check("sw_mis", {31'b0, last_mis}, 32'd1);
        ld("mis_nowrite", 32'h04, 2'b10, 1'b0, 32'h0);
        check("fault_set", {31'b0, last_fault}, 32'd1);
        ld("oor_rd", 32'h100, 2'b10, 1'b0, 32'h0);
        check("oor_flag", {31'b0, last_oor}, 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 32'h08, 2'b11, 1'b0, 32'h0, 1'b1);
        check("size11_mis", {31'b0, last_mis}, 32'd1);

        // Reset clears fault and data.
        st(32'h3C, 2'b10, 32'h11);
        ld("pre_rst", 32'h3C, 2'b10, 1'b0, 32'h11);
        rst_cycle();
        idle();
        check("fault_clr", {31'b0, last_fault}, 32'd0);
        wait_clear(n);
        check("clear_len2", n, 63);
        ld("post_rst", 32'h3C, 2'b10, 1'b0, 32'h0);

        // Busy lockout and mid-clear reset.
        rst_cycle();
        for (int i = 0; i < 10; i++) idle();
        st(32'h0, 2'b10, 32'hDEAD_BEEF);
        for (int i = 11; i < 30; i++) idle();
        check("lock_fault", {31'b0, last_fault}, 32'd0);
        rst_cycle();
        wait_clear(n);
        check("clear_len3", n, 64);
        ld("lock_data", 32'h0, 2'b10, 1'b0, 32'h0);
        check("lock_fault2", {31'b0, last_fault}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0) a = $urandom;
            else if (sel == 1) a = 32'(NBYTES - 4 + $urandom_range(0, 7));
            else a = 32'($urandom_range(0, NBYTES - 1));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0)
                cycle(1'b0, 1'b0, 1'b0, a, sz, 1'b0, 32'h0, 1'b1);
            else
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz,
                      1'($urandom_range(0, 1)), $urandom, 1'b1);
        end
        for (int i = 0; i < NBYTES; i += 4) begin
            if (m_clr_left == 0) ld("final_sweep", 32'(i), 2'b10, 1'b0, m_rdata(32'(i), 2'b10, 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Byte-addressed, parametrised data memory for the single-cycle CPU datapath; replaces the fixed 64-word, word-indexed data memory.
- Adds:
  - byte, halfword and word loads/stores with sign or zero extension;
  - alignment and range checking with a sticky fault flag;
  - a hardware clear sequencer that zeroes every word after reset.
- Sits between the ALU address output and the register-file write-back mux.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, at least 4.
- IDX_W, log2(DEPTH_WORDS) = 6, word-index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- addr  in  32  byte address of the access.
- wdata  in  32  store data; the low byte or halfword is used for narrow stores.
- we  in  1  store request for this cycle.
- re  in  1  load request for this cycle; gates fault detection only, not rdata.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- uns  in  1  1 = zero-extend narrow loads; 0 = sign-extend.
- rdata  out  32  load result; combinational from addr/size/uns.
- misalign  out  1  combinational: current access is misaligned or size==11.
- oor  out  1  combinational: current access is out of range.
- fault  out  1  sticky: a faulting access occurred.
- busy  out  1  1 while the clear sequencer runs.

Behaviour:
- Storage and lanes:
  - Storage is DEPTH_WORDS x 32. Word index = addr[IDX_W+1:2]. Byte lane = addr[1:0].
  - Little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- misalign = (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (size==11).
- oor = addr >= 4*DEPTH_WORDS, using the full 32-bit comparison.
- bad = misalign | oor.
- Reads (combinational, zero latency):
  - Byte: selected lane, extended to 32 bits.
  - Halfword: lanes {addr[1]*2+1, addr[1]*2}, extended to 32 bits.
  - Word: the whole word; uns is ignored.
  - rdata = 0 when bad=1 or busy=1.
- Stores:
  - Committed on the rising edge when we=1 & bad=0 & busy=0 & rst_n=1.
  - Only the addressed lanes change. Byte writes wdata[7:0]; halfword writes wdata[15:0] into its two lanes; word writes all 32 bits.
  - A suppressed store changes no memory bit.
- fault:
  - Set on a rising edge where (we|re)=1 & bad=1 & busy=0.
  - Held until reset. Reset value 0.
- Clear sequencer, states CLEAR and READY:
  - While rst_n=0 on an edge: state<=CLEAR, clr_idx<=0, fault<=0. Memory contents are not touched on that edge.
  - CLEAR with rst_n=1: mem[clr_idx]<=0, clr_idx<=clr_idx+1. After the edge that clears index DEPTH_WORDS-1, state<=READY.
  - The clear therefore takes exactly DEPTH_WORDS cycles after rst_n rises.
  - READY: holds until the next reset.
  - busy = (state==CLEAR); it reads 1 during reset and after it.
  - Loads and stores issued while busy=1 are ignored and never set fault.
- Reset mid-clear: clr_idx restarts at 0 and the full DEPTH_WORDS-cycle clear repeats.
- Reset in READY: the memory is re-cleared. Software must not rely on contents surviving reset.
- Power-up state before the first reset is undefined. The bench must apply rst_n=0 for at least one edge first.
- Simultaneous we and re to the same address:
  - rdata shows the old contents during the cycle.
  - The new value is visible after the edge.
- clr_idx is IDX_W+1 bits wide, or compares against DEPTH_WORDS-1 before wrapping; it never wraps into a second pass.

Test Plan:
- Clear timing: rst_n=0 for 2 edges, then 1. busy stays 1 for exactly 64 edges then falls. Every word-aligned load 0x00..0xFC returns 0x00000000.
- Word store then narrow loads: store word 0x8000_F0A5 at 0x10. Expected results:
  - LB 0x10 signed → 0xFFFFFFA5; LB 0x10 uns → 0x000000A5.
  - LH 0x12 signed → 0xFFFF8000; LH 0x12 uns → 0x00008000.
  - LW 0x10 → 0x8000F0A5.
- Byte and halfword merge: after clear, SB 0x7F to 0x21, then SH 0xBEEF to 0x22. LW 0x20 → 0xBEEF7F00.
- Misalign and range: SW 0x12345678 to 0x06 → misalign=1, fault=1 after the edge, LW 0x04 still 0. LW 0x100 → oor=1, rdata=0. size=11 → misalign=1.
- Busy lockout and mid-clear reset: SW 0xDEADBEEF to 0x0 at clear cycle 10 → ignored, fault stays 0. Assert rst_n=0 at clear cycle 30 → busy lasts 64 more cycles from release.
- Reset clears fault and data: set fault via a misaligned access, store 0x11 to 0x3C, then reset. fault=0, and LW 0x3C → 0 once busy=0.
